// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: banked synchronous SRAM model with its own access sequencer.
// Each request runs the sequence PRE -> ACCESS (ACCESS_CYCLES cycles) -> DONE.
// Banks are low-order interleaved. The controller also provides byte write
// enables, out-of-range error reporting and a power-down (SLEEP/WAKE) path.
//
// Ports:
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   cs_n, we_n      request strobe (active low); 0 = write, 1 = read
//   addr, wdata     word address and write data, latched on accept
//   be_n            byte write enables, active low
//   pd              power-down request
//   ready           a request can be accepted this cycle (combinational)
//   rdata, rvalid   read data and one-cycle read-complete pulse
//   wdone           one-cycle write-complete pulse
//   err             out-of-range flag, coincident with rvalid/wdone
//   busy_bank       one-hot bank in use during PRE/ACCESS
module sram_bank_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 768,
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs_n,
  input  logic                    we_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be_n,
  input  logic                    pd,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    wdone,
  output logic                    err,
  output logic [NUM_BANKS-1:0]    busy_bank
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned BANK_SH = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? BANK_SH : 1;
  localparam int unsigned ROWS    = MEM_DEPTH / NUM_BANKS;
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned AW1     = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, PRE, ACCESS, DONE, SLEEP, WAKE} state_t;

  typedef struct packed {
    logic                  we_n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be_n;
  } req_t;

  // Address falls inside the implemented depth
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < AW1'(MEM_DEPTH);
  endfunction

  // One-hot bank for an address; zero when out of range
  function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [ADDR_WIDTH-1:0] a);
    logic [BANK_W-1:0] b;
    b = BANK_W'(a & ADDR_WIDTH'(NUM_BANKS - 1));
    return addr_ok(a) ? (NUM_BANKS'(1) << b) : '0;
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wdone_q, wdone_d;
  logic                  err_q, err_d;
  logic [NUM_BANKS-1:0]  busy_q, busy_d;

  logic                  accept;
  logic                  commit;
  logic                  in_range;
  logic [BANK_W-1:0]     bank_idx;
  logic [ROW_W-1:0]      row_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // ready follows pd in IDLE without a cycle of lag so a sleeping request is never taken
  assign ready    = ((state_q == IDLE) && !pd) || (state_q == DONE);
  assign accept   = ready && !cs_n;
  assign commit   = (state_q == ACCESS) && (cnt_q == '0);
  assign in_range = addr_ok(req_q.addr);
  assign bank_idx = BANK_W'(req_q.addr & ADDR_WIDTH'(NUM_BANKS - 1));
  assign row_idx  = ROW_W'(req_q.addr >> BANK_SH);
  assign rd_word  = mem[bank_idx][row_idx];

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign wdone     = wdone_q;
  assign err       = err_q;
  assign busy_bank = busy_q;

  // Next-state, request latch and registered-output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = '0;

    if (accept) begin
      req_d.we_n  = we_n;
      req_d.addr  = addr;
      req_d.wdata = wdata;
      req_d.be_n  = be_n;
    end

    case (state_q)
      IDLE: begin
        if (accept)  state_d = PRE;
        else if (pd) state_d = SLEEP;
      end
      PRE: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (req_q.we_n) rdata_d = in_range ? rd_word : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (accept)  state_d = PRE;
        else if (pd) state_d = SLEEP;
        else         state_d = IDLE;
      end
      SLEEP: begin
        if (!pd) state_d = WAKE;
      end
      WAKE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pulses are set on entry to DONE so they are visible during the DONE cycle
    rvalid_d = (state_d == DONE) && req_d.we_n;
    wdone_d  = (state_d == DONE) && !req_d.we_n;
    err_d    = (state_d == DONE) && !addr_ok(req_d.addr);
    if ((state_d == PRE) || (state_d == ACCESS)) busy_d = bank_sel(req_d.addr);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Array is not reset; a reset before the commit edge clears state_q and drops the write
  always_ff @(posedge clk) begin
    if (commit && !req_q.we_n && in_range) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (!req_q.be_n[b]) mem[bank_idx][row_idx][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed self-checking bench for sram_bank_ctrl. The default instance
// (ACCESS_CYCLES=2) carries the main sequence. Two extra instances
// (ACCESS_CYCLES=1 and 4) share its inputs for the latency checks.
module tb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n, we_n, pd;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be_n;

  logic        ready, rvalid, wdone, err;
  logic [31:0] rdata;
  logic [3:0]  busy;
  logic        ready1, rvalid1, wdone1, err1;
  logic [31:0] rdata1;
  logic [3:0]  busy1;
  logic        ready4, rvalid4, wdone4, err4;
  logic [31:0] rdata4;
  logic [3:0]  busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(768), .NUM_BANKS(4),
                   .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .wdata(wdata),
    .be_n(be_n), .pd(pd), .ready(ready), .rdata(rdata), .rvalid(rvalid), .wdone(wdone),
    .err(err), .busy_bank(busy));

  sram_bank_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(768), .NUM_BANKS(4),
                   .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .wdata(wdata),
    .be_n(be_n), .pd(pd), .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .wdone(wdone1),
    .err(err1), .busy_bank(busy1));

  sram_bank_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(768), .NUM_BANKS(4),
                   .ACCESS_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .wdata(wdata),
    .be_n(be_n), .pd(pd), .ready(ready4), .rdata(rdata4), .rvalid(rvalid4), .wdone(wdone4),
    .err(err4), .busy_bank(busy4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on the main instance, from IDLE or DONE; returns in its DONE cycle
  task automatic run(input logic w_n, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_rd, input string tag);
    logic       ok;
    logic [3:0] eb;
    ok = (a < 10'd768);
    eb = ok ? (4'b0001 << a[1:0]) : 4'b0000;
    cs_n = 1'b0; we_n = w_n; addr = a; wdata = d; be_n = be;
    #1;
    chk({tag, ".ready_in"}, ready, 1);
    @(negedge clk);                         // accepting edge
    cs_n = 1'b1; we_n = ~w_n; addr = ~a; wdata = ~d; be_n = ~be;
    chk({tag, ".ready_pre"}, ready, 0);
    chk({tag, ".busy_pre"}, busy, eb);
    @(negedge clk);                         // edge 1
    chk({tag, ".busy_acc"}, busy, eb);
    @(negedge clk);                         // edge 2
    chk({tag, ".pulse_e2"}, {rvalid, wdone}, 0);
    @(negedge clk);                         // edge 3
    chk({tag, ".rvalid"}, rvalid, w_n);
    chk({tag, ".wdone"}, wdone, !w_n);
    chk({tag, ".err"}, err, !ok);
    chk({tag, ".busy_done"}, busy, 0);
    if (w_n) chk({tag, ".rdata"}, rdata, exp_rd);
    cs_n = 1'b1;
  endtask

  initial begin
    logic [5:0] p_rdy1, p_wd1, p_rdy4, p_wd4, p_rdy, p_wd;
    rst_n = 1'b0; cs_n = 1'b1; we_n = 1'b1; pd = 1'b0;
    addr = '0; wdata = '0; be_n = '1;
    repeat (2) @(negedge clk);
    chk("rst.ready", ready, 1);
    chk("rst.rvalid", rvalid, 0);
    chk("rst.wdone", wdone, 0);
    chk("rst.err", err, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 10'h005, 32'hDEADBEEF, 4'b0000, 32'h0, "w005");
    @(negedge clk);
    run(1'b1, 10'h005, 32'h0, 4'b1111, 32'hDEADBEEF, "r005");
    @(negedge clk);
    run(1'b0, 10'h005, 32'h11223344, 4'b1010, 32'h0, "w005_be");
    @(negedge clk);
    run(1'b1, 10'h005, 32'h0, 4'b1111, 32'hDE22BE44, "r005_be");
    @(negedge clk);

    // Back-to-back chain: each request accepted in the previous one's DONE
    run(1'b0, 10'h2FF, 32'hCAFEF00D, 4'b0000, 32'h0, "w2ff");
    run(1'b0, 10'h3FF, 32'h0BADBAD0, 4'b0000, 32'h0, "b2b_w3ff");
    run(1'b1, 10'h2FF, 32'h0, 4'b1111, 32'hCAFEF00D, "b2b_r2ff");
    run(1'b1, 10'h3FF, 32'h0, 4'b1111, 32'h0, "b2b_r3ff");
    run(1'b0, 10'h100, 32'h12345678, 4'b0000, 32'h0, "b2b_w100");
    run(1'b1, 10'h100, 32'h0, 4'b1111, 32'h12345678, "b2b_r100");
    run(1'b0, 10'h100, 32'h0, 4'b1111, 32'h0, "b2b_w100_nobe");
    run(1'b1, 10'h100, 32'h0, 4'b1111, 32'h12345678, "b2b_r100_nobe");
    @(negedge clk);

    // Latency across ACCESS_CYCLES = 1, 2, 4; bit e is the value after edge e
    repeat (12) @(negedge clk);
    p_rdy1 = 6'b111100; p_wd1 = 6'b000100;
    p_rdy  = 6'b111000; p_wd  = 6'b001000;
    p_rdy4 = 6'b100000; p_wd4 = 6'b100000;
    cs_n = 1'b0; we_n = 1'b0; addr = 10'h020; wdata = 32'h1; be_n = 4'b0000;
    #1;
    chk("lat.ready1_in", ready1, 1);
    chk("lat.ready4_in", ready4, 1);
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      cs_n = 1'b1;
      chk($sformatf("lat.ready1_e%0d", e), ready1, p_rdy1[e]);
      chk($sformatf("lat.wdone1_e%0d", e), wdone1, p_wd1[e]);
      chk($sformatf("lat.ready2_e%0d", e), ready, p_rdy[e]);
      chk($sformatf("lat.wdone2_e%0d", e), wdone, p_wd[e]);
      chk($sformatf("lat.ready4_e%0d", e), ready4, p_rdy4[e]);
      chk($sformatf("lat.wdone4_e%0d", e), wdone4, p_wd4[e]);
    end
    repeat (2) @(negedge clk);

    // Power-down with a pending write strobe that must be ignored
    pd = 1'b1; cs_n = 1'b0; we_n = 1'b0; addr = 10'h005; wdata = 32'h0; be_n = 4'b0000;
    #1;
    chk("pd.ready_idle", ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("pd.ready_c%0d", i), ready, 0);
    end
    chk("pd.wdone", wdone, 0);
    chk("pd.busy", busy, 0);
    pd = 1'b0; cs_n = 1'b1;
    #1;
    chk("pd.ready_sleep", ready, 0);
    @(negedge clk);
    chk("pd.ready_wake", ready, 0);
    @(negedge clk);
    chk("pd.ready_idle2", ready, 1);
    run(1'b1, 10'h005, 32'h0, 4'b1111, 32'hDE22BE44, "r005_sleep");
    @(negedge clk);

    // Reset during ACCESS aborts a write
    run(1'b0, 10'h010, 32'hA5A5A5A5, 4'b0000, 32'h0, "w010");
    chk("hold.rdata", rdata, 32'hDE22BE44);
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b0; addr = 10'h010; wdata = 32'h0; be_n = 4'b0000;
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    chk("abort.in_access_busy", busy, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("abort.ready", ready, 1);
    chk("abort.rvalid", rvalid, 0);
    chk("abort.wdone", wdone, 0);
    chk("abort.err", err, 0);
    chk("abort.rdata", rdata, 0);
    chk("abort.busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort.no_wdone", wdone, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b1, 10'h010, 32'h0, 4'b1111, 32'hA5A5A5A5, "r010_after_rst");
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Parametrised, banked, synchronous SRAM macro model with its own access sequencer: precharge, access (write-drive or sense), done.
- Successor to the fixed-size single-bank SRAM top: generalised width, depth and bank count, plus byte-write enables, configurable access time, a ready/valid handshake, address-range error reporting and a power-down mode.
- Sits behind the bus-side agent; the UVC drives requests and checks rdata against a scoreboard.

Parameters:
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MEM_DEPTH, 768, implemented words; must be ≤ 2^ADDR_WIDTH and a multiple of NUM_BANKS.
- NUM_BANKS, 4, power of two, ≥ 1; bank = addr[log2(NUM_BANKS)-1:0] (low-order interleave), row = addr >> log2(NUM_BANKS).
- ACCESS_CYCLES, 2, cycles spent in ACCESS, ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs_n  input  1  request strobe, active low.
- we_n  input  1  0 = write, 1 = read; sampled with cs_n.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  DATA_WIDTH  write data.
- be_n  input  DATA_WIDTH/8  byte write enables, active low.
- pd  input  1  power-down request.
- ready  output  1  the block can accept a request this cycle.
- rdata  output  DATA_WIDTH  read data, valid while rvalid = 1.
- rvalid  output  1  one-cycle read-complete pulse.
- wdone  output  1  one-cycle write-complete pulse.
- err  output  1  one-cycle pulse, coincident with rvalid/wdone, for an out-of-range address.
- busy_bank  output  NUM_BANKS  one-hot bank in use; 0 when idle.

Behaviour:
- Reset (async assert, sync release): state IDLE, ready=1, rvalid=0, wdone=0, err=0, rdata=0, busy_bank=0, access counter=0.
- Memory array contents are not reset; unwritten words read X in simulation.
- States: IDLE, PRE, ACCESS, DONE, SLEEP, WAKE.
- Accept: a request is accepted on a rising edge when cs_n=0 and ready=1. ready=1 only in IDLE and DONE, and is 0 in IDLE while pd=1.
- On accept, addr, we_n, wdata and be_n are latched. Inputs are ignored while ready=0.
- IDLE: on accept -> PRE. If pd=1 and no accept -> SLEEP. Accept has priority only while pd=0, because ready=0 when pd=1.
- PRE: 1 cycle; busy_bank = decoded bank. Next state is ACCESS, counter loaded with ACCESS_CYCLES-1.
- ACCESS: the counter decrements each cycle. On the edge leaving ACCESS at counter=0:
  - Write: enabled bytes are committed; disabled bytes are unchanged.
  - Read: the word is captured into rdata.
  - Next state is DONE.
- DONE: 1 cycle; rvalid=1 (read) or wdone=1 (write); err=1 if the latched addr ≥ MEM_DEPTH. busy_bank=0.
  - If a request is accepted in DONE -> PRE directly (back-to-back).
  - Else if pd=1 -> SLEEP.
  - Else -> IDLE.
- Latency: rvalid/wdone is asserted for the cycle following the (ACCESS_CYCLES+1)th rising edge after the accepting edge. Default: the 3rd edge.
  - Back-to-back throughput: one request per ACCESS_CYCLES+2 cycles.
- Out-of-range address:
  - Write: no array change.
  - Read: rdata=0.
  - Both: err=1 with the completion pulse; busy_bank=0 throughout.
- rdata holds its last value until the next read completion. It is 0 after reset.
- SLEEP: ready=0. The array retains its contents. When pd=0 -> WAKE (1 cycle, ready=0) -> IDLE.
- Reset mid-operation: asserting rst_n=0 before the commit edge aborts the access.
  - A pending write is not committed.
  - No rvalid, wdone or err pulse is produced.
- Read of a word written by the immediately preceding back-to-back write returns the new data.
- be_n=all ones write: completes normally with wdone, array unchanged.

Test Plan:
- Reset, then write addr 0x005, wdata 0xDEADBEEF, be_n 0 -> wdone on edge 3 after accept; read 0x005 -> rvalid on edge 3, rdata 0xDEADBEEF, err 0, busy_bank 4'b0010 during PRE/ACCESS.
- Write 0x005 with wdata 0x11223344, be_n 4'b1010 over the prior value -> read returns 0xDE22BE44.
- Back-to-back: write 0x3FF in DONE-accepted sequence, then read 0x2FF -> second request accepted in DONE of the first, PRE follows immediately.
  - Read of 0x3FF -> err=1, rdata 0 (MEM_DEPTH=768).
  - Read of 0x2FF -> valid data, err=0.
- Vary ACCESS_CYCLES=1 and 4 -> completion pulse on edge 2 and edge 5 respectively; ready low for exactly ACCESS_CYCLES+1 cycles after an accept from IDLE.
- Assert pd in IDLE for 10 cycles with cs_n=0 -> no accept, ready=0. Deassert pd -> WAKE then IDLE (ready high 2 cycles after pd drops). A subsequent read returns data written before sleep.
- Write 0x010 = 0xA5A5A5A5. Then write 0x010 = 0x0 and pull rst_n low during ACCESS -> no wdone, all outputs at reset values. A read after release returns 0xA5A5A5A5.
